butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 DIT butterfly for the streaming FFT engine. It computes sum = A + W·B and diff = A − W·B on packed complex words, with configurable component and twiddle widths. Per-sample modes select inverse transform (conjugate twiddle) and per-stage scaling by 1/2. It has a valid/ready handshake with full backpressure, rounding, saturation and a sticky overflow flag, so the FFT stage controller can chain instances stage to stage.

Parameters:
DATA_W, 18, bits per real/imag component of A, B, sum and diff (two's complement).
TW_W, 18, bits per real/imag component of W; Q1.(TW_W−1) fraction.
SATURATE, 1, 1 = clip results to the DATA_W range; 0 = wrap (two's-complement truncation).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input sample present.
in_ready  out  1  block accepts the input this cycle.
a  in  2*DATA_W  {real, imag}, real in the upper half.
b  in  2*DATA_W  {real, imag}.
w  in  2*TW_W  twiddle {real, imag}.
inverse  in  1  use conj(W); sampled with in_valid.
scale  in  1  divide both outputs by 2 with rounding; sampled with in_valid.
out_valid  out  1  output sample present.
out_ready  in  1  downstream accepts the output.
sum  out  2*DATA_W  A + W·B, packed {real, imag}.
diff  out  2*DATA_W  A − W·B, packed {real, imag}.
ovf  out  1  sticky; set when any output component was clipped or wrapped.
ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset, async: out_valid=0, sum=0, diff=0, ovf=0, all pipeline valid bits = 0. in_ready=1 after reset is released.
- Handshake: advance = !out_valid | out_ready. in_ready = advance. Input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready. When advance=0, every stage holds data and valid, and sum/diff stay stable.
- Latency: 3 cycles with no stall. Throughput: 1 sample per cycle. Stage valid bits and the mode bits travel with the data.
- S1 (register on transfer): A is registered. If inverse=1, w_im is negated in TW_W+1 bits, so −(−2^(TW_W−1)) stays exact. Four full-width signed products are formed: wr·br, wi·bi, wi·br, wr·bi.
- S2: the real product sum is P_re = wr·br − wi·bi. The imaginary product sum is P_im = wi·br + wr·bi. Each is then rounded half-up: (P + 2^(TW_W−2)) >>> (TW_W−1), kept at DATA_W+2 bits with no truncation.
- S3: s = A + WB and d = A − WB, per component, in DATA_W+3 bits.
  - If scale: x = (x + 1) >>> 1.
  - Each component is then reduced to DATA_W bits. SATURATE=1 clips to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. SATURATE=0 keeps the low DATA_W bits.
  - Out-of-range is detected in both modes.
- ovf is set on the cycle a sample with any out-of-range component enters the output register. ovf_clr clears it. If set and clear happen in the same cycle, set wins.
- Mode bits take effect per sample. Changing inverse/scale between back-to-back samples needs no bubble.
- Reset mid-operation: all in-flight samples are discarded and no partial output appears. The first sample accepted after reset emerges exactly 3 cycles later.
- All arithmetic is signed. Widths are derived from the parameters only, with no hard-coded 18.

Test Plan:
- Identity twiddle: a=(1000,0), b=(500,0), w=(131071,0), scale=0 → after 3 cycles sum=(1500,0), diff=(500,0), ovf=0.
- −j twiddle and inverse: a=(0,0), b=(500,0), w=(0,−131072). With inverse=0 → sum=(0,−500), diff=(0,500). With inverse=1 on the next cycle → sum=(0,500), diff=(0,−500). This shows back-to-back mode switching.
- Scaling/rounding: b=(0,0), scale=1. a=(1001,−1001) → sum=diff=(501,−500). a=(1,−1) → (1,0).
- Saturation: a=(131071,0), b=(131071,0), w=(−131072,0).
  - SATURATE=1 → sum=(0,0), diff=(131071,0), ovf=1.
  - SATURATE=0 → diff real wraps to −2, ovf=1.
  - Pulse ovf_clr → ovf=0. ovf_clr coincident with a new overflow → ovf stays 1.
- Backpressure: stream 6 samples continuously with out_ready low for cycles 4–7 → in_ready low for the same cycles. Outputs stay stable and all 6 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst with 2 samples in flight → out_valid drops immediately. After release, one new sample → out_valid exactly 3 cycles after acceptance, with the correct value.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: sum = A + W*B, diff = A - W*B over three register stages.
// Global-stall valid/ready, per-sample inverse/scale, half-up rounding, clip or wrap, sticky ovf.
module butterfly_pipe #(
    parameter int unsigned DATA_W   = 18,
    parameter int unsigned TW_W     = 18,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] a,
    input  logic [2*DATA_W-1:0] b,
    input  logic [2*TW_W-1:0]   w,
    input  logic                inverse,
    input  logic                scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] sum,
    output logic [2*DATA_W-1:0] diff,
    output logic                ovf,
    input  logic                ovf_clr
);
    localparam int unsigned PW  = DATA_W + TW_W + 1;
    localparam int unsigned PW1 = PW + 1;
    localparam int unsigned RW  = DATA_W + 2;
    localparam int unsigned XW  = DATA_W + 3;
    localparam logic signed [PW:0]   RND  = {{(PW1-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [XW-1:0] MAXV = {4'b0000, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = {4'b1111, {(DATA_W-1){1'b0}}};

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage 1: twiddle components carried in TW_W+1 bits so negating -2^(TW_W-1) stays exact.
    logic signed [TW_W:0]     w_wr, w_wi_raw, w_wi;
    logic signed [DATA_W-1:0] w_br, w_bi;
    logic signed [PW-1:0]     w_prr, w_pii, w_pir, w_pri;

    assign w_wr     = $signed({w[2*TW_W-1], w[2*TW_W-1:TW_W]});
    assign w_wi_raw = $signed({w[TW_W-1], w[TW_W-1:0]});
    assign w_wi     = inverse ? -w_wi_raw : w_wi_raw;
    assign w_br     = $signed(b[2*DATA_W-1:DATA_W]);
    assign w_bi     = $signed(b[DATA_W-1:0]);
    assign w_prr    = PW'(w_wr) * PW'(w_br);
    assign w_pii    = PW'(w_wi) * PW'(w_bi);
    assign w_pir    = PW'(w_wi) * PW'(w_br);
    assign w_pri    = PW'(w_wr) * PW'(w_bi);

    logic                     r1_valid, r1_scale;
    logic signed [DATA_W-1:0] r1_ar, r1_ai;
    logic signed [PW-1:0]     r1_prr, r1_pii, r1_pir, r1_pri;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_scale <= 1'b0;
            r1_ar    <= '0;
            r1_ai    <= '0;
            r1_prr   <= '0;
            r1_pii   <= '0;
            r1_pir   <= '0;
            r1_pri   <= '0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            if (in_valid) begin
                r1_scale <= scale;
                r1_ar    <= $signed(a[2*DATA_W-1:DATA_W]);
                r1_ai    <= $signed(a[DATA_W-1:0]);
                r1_prr   <= w_prr;
                r1_pii   <= w_pii;
                r1_pir   <= w_pir;
                r1_pri   <= w_pri;
            end
        end
    end

    // Stage 2: combine products and round half-up; selecting bits TW_W-1 upward is the >>> (TW_W-1).
    logic signed [PW:0] w_pre, w_pim;
    logic               w_unused;

    assign w_pre    = PW1'(r1_prr) - PW1'(r1_pii) + RND;
    assign w_pim    = PW1'(r1_pir) + PW1'(r1_pri) + RND;
    assign w_unused = ^{w_pre[PW], w_pre[TW_W-2:0], w_pim[PW], w_pim[TW_W-2:0]};

    logic                     r2_valid, r2_scale;
    logic signed [DATA_W-1:0] r2_ar, r2_ai;
    logic signed [RW-1:0]     r2_pre, r2_pim;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_scale <= 1'b0;
            r2_ar    <= '0;
            r2_ai    <= '0;
            r2_pre   <= '0;
            r2_pim   <= '0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_scale <= r1_scale;
                r2_ar    <= r1_ar;
                r2_ai    <= r1_ai;
                r2_pre   <= w_pre[TW_W-1 +: RW];
                r2_pim   <= w_pim[TW_W-1 +: RW];
            end
        end
    end

    // Stage 3 order: sum re, sum im, diff re, diff im.
    logic signed [XW-1:0] w_raw [4];
    logic signed [XW-1:0] w_x   [4];
    logic [DATA_W-1:0]    w_red [4];
    logic [3:0]           w_oor;

    always_comb begin
        w_raw[0] = XW'(r2_ar) + XW'(r2_pre);
        w_raw[1] = XW'(r2_ai) + XW'(r2_pim);
        w_raw[2] = XW'(r2_ar) - XW'(r2_pre);
        w_raw[3] = XW'(r2_ai) - XW'(r2_pim);
        for (int unsigned i = 0; i < 4; i++) begin
            w_x[i]   = r2_scale ? ((w_raw[i] + XW'(1)) >>> 1) : w_raw[i];
            w_oor[i] = (w_x[i] > MAXV) || (w_x[i] < MINV);
            if (SATURATE && (w_x[i] > MAXV)) begin
                w_red[i] = {1'b0, {(DATA_W-1){1'b1}}};
            end else if (SATURATE && (w_x[i] < MINV)) begin
                w_red[i] = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                w_red[i] = w_x[i][DATA_W-1:0];
            end
        end
    end

    logic                r_out_valid, r_ovf;
    logic [2*DATA_W-1:0] r_sum, r_diff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_diff      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_adv) begin
                r_out_valid <= r2_valid;
                if (r2_valid) begin
                    r_sum  <= {w_red[0], w_red[1]};
                    r_diff <= {w_red[2], w_red[3]};
                end
            end
            if (w_adv && r2_valid && (|w_oor)) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign diff      = r_diff;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: directed cases plus randomized streams against a
// plain-arithmetic reference model; a clipping and a wrapping instance share the same stimulus.
`timescale 1ns/1ps
module tb_butterfly_pipe;
    localparam int DW = 18;
    localparam int TW = 18;

    logic          clk = 1'b0;
    logic          rst, in_valid, inverse, scale, out_ready, ovf_clr;
    logic [2*DW-1:0] a, b;
    logic [2*TW-1:0] w;
    logic          in_ready_s, out_valid_s, ovf_s;
    logic          in_ready_w, out_valid_w, ovf_w;
    logic [2*DW-1:0] sum_s, diff_s, sum_w, diff_w;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2*DW-1:0] s_sat, d_sat, s_wrap, d_wrap;
        bit              oor;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    butterfly_pipe #(.DATA_W(DW), .TW_W(TW), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .w(w), .inverse(inverse), .scale(scale),
        .out_valid(out_valid_s), .out_ready(out_ready), .sum(sum_s), .diff(diff_s),
        .ovf(ovf_s), .ovf_clr(ovf_clr)
    );

    butterfly_pipe #(.DATA_W(DW), .TW_W(TW), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .w(w), .inverse(inverse), .scale(scale),
        .out_valid(out_valid_w), .out_ready(out_ready), .sum(sum_w), .diff(diff_w),
        .ovf(ovf_w), .ovf_clr(ovf_clr)
    );

    function automatic logic [2*DW-1:0] pk(input int re, input int im);
        logic [DW-1:0] r, i;
        r = re[DW-1:0];
        i = im[DW-1:0];
        return {r, i};
    endfunction

    function automatic logic [2*TW-1:0] pkw(input int re, input int im);
        logic [TW-1:0] r, i;
        r = re[TW-1:0];
        i = im[TW-1:0];
        return {r, i};
    endfunction

    function automatic longint sx_d(input logic [DW-1:0] v);
        longint t;
        t = $signed(v);
        return t;
    endfunction

    function automatic longint sx_t(input logic [TW-1:0] v);
        longint t;
        t = $signed(v);
        return t;
    endfunction

    // Reference: complex multiply, half-up rounding of the Q1.(TW-1) product, add/sub, optional halving.
    function automatic exp_t model(input logic [2*DW-1:0] av, input logic [2*DW-1:0] bv,
                                   input logic [2*TW-1:0] wv, input bit inv, input bit scl);
        exp_t          e;
        longint        ar, ai, br, bi, wr, wi, pre, pim, lo, hi, half, one;
        longint        x[4];
        logic [DW-1:0] sat[4], wrp[4];
        ar = sx_d(av[2*DW-1:DW]);  ai = sx_d(av[DW-1:0]);
        br = sx_d(bv[2*DW-1:DW]);  bi = sx_d(bv[DW-1:0]);
        wr = sx_t(wv[2*TW-1:TW]);  wi = sx_t(wv[TW-1:0]);
        if (inv) wi = -wi;
        one  = 1;
        half = one <<< (TW - 2);
        pre  = (wr * br - wi * bi + half) >>> (TW - 1);
        pim  = (wi * br + wr * bi + half) >>> (TW - 1);
        x[0] = ar + pre;  x[1] = ai + pim;
        x[2] = ar - pre;  x[3] = ai - pim;
        hi = (one <<< (DW - 1)) - 1;
        lo = -(one <<< (DW - 1));
        e.oor = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (scl) x[i] = (x[i] + 1) >>> 1;
            if (x[i] > hi || x[i] < lo) e.oor = 1'b1;
            wrp[i] = x[i][DW-1:0];
            if (x[i] > hi)      sat[i] = hi[DW-1:0];
            else if (x[i] < lo) sat[i] = lo[DW-1:0];
            else                sat[i] = x[i][DW-1:0];
        end
        e.s_sat  = {sat[0], sat[1]};  e.d_sat  = {sat[2], sat[3]};
        e.s_wrap = {wrp[0], wrp[1]};  e.d_wrap = {wrp[2], wrp[3]};
        return e;
    endfunction

    function automatic int rnd_comp(input bit big);
        if (big) return int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic set_sample(input logic [2*DW-1:0] av, input logic [2*DW-1:0] bv,
                              input logic [2*TW-1:0] wv, input bit inv, input bit scl);
        a = av; b = bv; w = wv; inverse = inv; scale = scl; in_valid = 1'b1;
    endtask

    task automatic set_random_sample();
        bit big;
        int wr, wi;
        big = ($urandom_range(0, 7) == 0);
        wr  = int'($urandom_range(0, (1 << TW) - 1)) - (1 << (TW - 1));
        wi  = int'($urandom_range(0, (1 << TW) - 1)) - (1 << (TW - 1));
        if ($urandom_range(0, 9) == 0) wi = -(1 << (TW - 1));
        set_sample(pk(rnd_comp(big), rnd_comp(big)), pk(rnd_comp(big), rnd_comp(big)),
                   pkw(wr, wi), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        a = '0; b = '0; w = '0; inverse = 1'b0; scale = 1'b0;
        #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) $display("FAIL reset_out_valid got %b/%b want 0", out_valid_s, out_valid_w);
        else n_pass++;
        n_checks++;
        if (sum_s !== '0 || diff_s !== '0 || sum_w !== '0 || diff_w !== '0) $display("FAIL reset_data got %h %h %h %h want 0", sum_s, diff_s, sum_w, diff_w);
        else n_pass++;
        n_checks++;
        if (ovf_s !== 1'b0 || ovf_w !== 1'b0) $display("FAIL reset_ovf got %b/%b want 0", ovf_s, ovf_w);
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready_s !== 1'b1 || in_ready_w !== 1'b1) $display("FAIL reset_in_ready got %b/%b want 1", in_ready_s, in_ready_w);
        else n_pass++;
        out_ready = 1'b1;
    endtask

    task automatic test_identity();
        @(negedge clk);
        set_sample(pk(1000, 0), pk(500, 0), pkw(131071, 0), 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b0) $display("FAIL identity_early got out_valid=%b want 0", out_valid_s);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b1 || sum_s !== pk(1500, 0) || diff_s !== pk(500, 0) || ovf_s !== 1'b0)
            $display("FAIL identity got v=%b sum=%h diff=%h ovf=%b want 1 %h %h 0", out_valid_s, sum_s, diff_s, ovf_s, pk(1500, 0), pk(500, 0));
        else n_pass++;
    endtask

    task automatic test_twiddle_inverse();
        @(negedge clk);
        set_sample(pk(0, 0), pk(500, 0), pkw(0, -131072), 1'b0, 1'b0);
        @(negedge clk);
        set_sample(pk(0, 0), pk(500, 0), pkw(0, -131072), 1'b1, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b1 || sum_s !== pk(0, -500) || diff_s !== pk(0, 500))
            $display("FAIL minus_j got v=%b sum=%h diff=%h want 1 %h %h", out_valid_s, sum_s, diff_s, pk(0, -500), pk(0, 500));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b1 || sum_s !== pk(0, 500) || diff_s !== pk(0, -500))
            $display("FAIL minus_j_inverse got v=%b sum=%h diff=%h want 1 %h %h", out_valid_s, sum_s, diff_s, pk(0, 500), pk(0, -500));
        else n_pass++;
    endtask

    task automatic test_scaling();
        @(negedge clk);
        set_sample(pk(1001, -1001), pk(0, 0), pkw(131071, 0), 1'b0, 1'b1);
        @(negedge clk);
        set_sample(pk(1, -1), pk(0, 0), pkw(131071, 0), 1'b0, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (sum_s !== pk(501, -500) || diff_s !== pk(501, -500) || sum_w !== pk(501, -500))
            $display("FAIL scale_1001 got sum=%h diff=%h want %h", sum_s, diff_s, pk(501, -500));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sum_s !== pk(1, 0) || diff_s !== pk(1, 0) || diff_w !== pk(1, 0))
            $display("FAIL scale_1 got sum=%h diff=%h want %h", sum_s, diff_s, pk(1, 0));
        else n_pass++;
    endtask

    task automatic test_saturation_ovf();
        n_checks++;
        if (ovf_s !== 1'b0 || ovf_w !== 1'b0) $display("FAIL ovf_quiet got %b/%b want 0", ovf_s, ovf_w);
        else n_pass++;
        @(negedge clk);
        set_sample(pk(131071, 0), pk(131071, 0), pkw(-131072, 0), 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++;
        if (sum_s !== pk(0, 0) || diff_s !== pk(131071, 0) || ovf_s !== 1'b1)
            $display("FAIL sat_clip got sum=%h diff=%h ovf=%b want %h %h 1", sum_s, diff_s, ovf_s, pk(0, 0), pk(131071, 0));
        else n_pass++;
        n_checks++;
        if (sum_w !== pk(0, 0) || diff_w !== pk(-2, 0) || ovf_w !== 1'b1)
            $display("FAIL sat_wrap got sum=%h diff=%h ovf=%b want %h %h 1", sum_w, diff_w, ovf_w, pk(0, 0), pk(-2, 0));
        else n_pass++;
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        n_checks++;
        if (ovf_s !== 1'b0 || ovf_w !== 1'b0) $display("FAIL ovf_clear got %b/%b want 0", ovf_s, ovf_w);
        else n_pass++;
        set_sample(pk(131071, 0), pk(131071, 0), pkw(-131072, 0), 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        ovf_clr = 1'b1;
        n_checks++;
        if (ovf_s !== 1'b0) $display("FAIL ovf_before_set got %b want 0", ovf_s);
        else n_pass++;
        @(negedge clk); ovf_clr = 1'b0;
        n_checks++;
        if (ovf_s !== 1'b1 || ovf_w !== 1'b1) $display("FAIL ovf_set_wins got %b/%b want 1", ovf_s, ovf_w);
        else n_pass++;
        ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
    endtask

    task automatic test_backpressure();
        int   sent = 0;
        int   got  = 0;
        exp_t e;
        q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 7);
            if (sent < 6) set_random_sample();
            else in_valid = 1'b0;
            #1;
            if (cyc < 10) begin
                n_checks++;
                if (in_ready_s !== out_ready) $display("FAIL bp_in_ready cyc=%0d got %b want %b", cyc, in_ready_s, out_ready);
                else n_pass++;
            end
            if (!out_ready) begin
                n_checks++;
                if (q.size() == 0 || out_valid_s !== 1'b1 || sum_s !== q[0].s_sat || diff_s !== q[0].d_sat)
                    $display("FAIL bp_hold cyc=%0d got v=%b sum=%h diff=%h queued=%0d", cyc, out_valid_s, sum_s, diff_s, q.size());
                else n_pass++;
            end
            if (in_valid && in_ready_s) begin
                q.push_back(model(a, b, w, inverse, scale));
                sent++;
            end
            if (out_valid_s && out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL bp_extra got unexpected output sum=%h", sum_s);
                else begin
                    e = q.pop_front();
                    if (sum_s !== e.s_sat || diff_s !== e.d_sat || sum_w !== e.s_wrap || diff_w !== e.d_wrap)
                        $display("FAIL bp_data #%0d got %h %h want %h %h", got, sum_s, diff_s, e.s_sat, e.d_sat);
                    else n_pass++;
                end
                got++;
            end
            if (got == 6 && cyc > 12) break;
        end
        in_valid = 1'b0;
        n_checks++;
        if (got !== 6 || q.size() != 0) $display("FAIL bp_count got %0d outputs want 6 (left %0d)", got, q.size());
        else n_pass++;
    endtask

    task automatic test_random_stream();
        localparam int N = 80;
        int   sent = 0;
        int   got  = 0;
        bit   any_oor = 1'b0;
        exp_t e;
        q.delete();
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b1;
        @(negedge clk); ovf_clr = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < N; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N && $urandom_range(0, 3) != 0) set_random_sample();
            else in_valid = 1'b0;
            #1;
            if (in_valid && in_ready_s) begin
                e = model(a, b, w, inverse, scale);
                any_oor |= e.oor;
                q.push_back(e);
                sent++;
            end
            if (out_valid_s && out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL rnd_extra got unexpected output sum=%h", sum_s);
                else begin
                    e = q.pop_front();
                    if (out_valid_w !== 1'b1 || sum_s !== e.s_sat || diff_s !== e.d_sat || sum_w !== e.s_wrap || diff_w !== e.d_wrap)
                        $display("FAIL rnd_data #%0d got %h %h %h %h want %h %h %h %h", got, sum_s, diff_s, sum_w, diff_w, e.s_sat, e.d_sat, e.s_wrap, e.d_wrap);
                    else n_pass++;
                end
                got++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got != N) $display("FAIL rnd_count got %0d outputs want %0d", got, N);
        else n_pass++;
        n_checks++;
        if (ovf_s !== any_oor || ovf_w !== any_oor) $display("FAIL rnd_ovf got %b/%b want %b", ovf_s, ovf_w, any_oor);
        else n_pass++;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        set_sample(pk(7, 7), pk(3, 3), pkw(65536, 0), 1'b0, 1'b0);
        @(negedge clk);
        set_sample(pk(8, 8), pk(3, 3), pkw(65536, 0), 1'b0, 1'b0);
        @(negedge clk);
        set_sample(pk(9, 9), pk(3, 3), pkw(65536, 0), 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid_s !== 1'b0 || sum_s !== '0 || diff_s !== '0)
            $display("FAIL midreset_async got v=%b sum=%h diff=%h want 0", out_valid_s, sum_s, diff_s);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid_s !== 1'b0 || out_valid_w !== 1'b0) $display("FAIL midreset_ghost cyc=%0d got %b want 0", i, out_valid_s);
            else n_pass++;
        end
        set_sample(pk(1000, 0), pk(500, 0), pkw(131071, 0), 1'b0, 1'b0);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b0) $display("FAIL midreset_early got %b want 0", out_valid_s);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid_s !== 1'b1 || sum_s !== pk(1500, 0) || diff_s !== pk(500, 0))
            $display("FAIL midreset_first got v=%b sum=%h diff=%h want 1 %h %h", out_valid_s, sum_s, diff_s, pk(1500, 0), pk(500, 0));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_twiddle_inverse();
        test_scaling();
        test_saturation_ovf();
        test_backpressure();
        test_random_stream();
        test_reset_midstream();
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end
endmodule
